// File: rtl/pkg_uniciclo.sv
// Shared types and constants for the single-cycle processor register bank.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pkg_uniciclo;

    localparam int LARGURA_DADO = 8;
    localparam int LARGURA_END  = 2;
    localparam int NUM_REGS     = 4;

    // One pending write to the bank: destination register and data word.
    typedef struct packed {
        logic [LARGURA_END-1:0]  registro;
        logic [LARGURA_DADO-1:0] dado;
    } req_escrita_t;

    // One-hot decode of a register address, qualified by a valid bit.
    function automatic logic [NUM_REGS-1:0] decodifica(input logic                   v,
                                                        input logic [LARGURA_END-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = v;
        return m;
    endfunction

endpackage

// File: rtl/estagio_saida_escrita.sv
// One-entry output stage driving the bank write port, plus pending-write decode.
// Latency: loaded at edge N, EscreveReg asserted during cycle N+1 unless stalled.
// Backpressure: stall holds contents; drain and reload in one cycle gives 1 write/cycle.
module estagio_saida_escrita
    import pkg_uniciclo::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    carrega_i,
    input  logic                    stall_i,
    input  req_escrita_t            entrada_i,
    input  logic                    id_i,
    output logic                    out_v_o,
    output logic                    escreve_o,
    output logic [LARGURA_END-1:0]  reg_o,
    output logic [LARGURA_DADO-1:0] dado_o,
    output logic                    id_o,
    output logic [NUM_REGS-1:0]     pend_mask_o
);

    logic         out_v_q, out_v_d;
    req_escrita_t dados_q, dados_d;
    logic         id_q, id_d;

    // Next state: a new transfer wins over drain (reload); drain alone empties the stage.
    always_comb begin
        out_v_d = out_v_q;
        dados_d = dados_q;
        id_d    = id_q;
        if (carrega_i) begin
            out_v_d = 1'b1;
            dados_d = entrada_i;
            id_d    = id_i;
        end else if (out_v_q && !stall_i) begin
            out_v_d = 1'b0;
        end
    end

    // Stage registers; reset discards any held write so it never reaches the bank.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_v_q <= 1'b0;
            dados_q <= '0;
            id_q    <= 1'b0;
        end else begin
            out_v_q <= out_v_d;
            dados_q <= dados_d;
            id_q    <= id_d;
        end
    end

    // Gated by reset too, so a write held when reset rises is never issued.
    assign escreve_o   = out_v_q && !stall_i && !reset;
    assign out_v_o     = out_v_q;
    assign reg_o       = dados_q.registro;
    assign dado_o      = dados_q.dado;
    assign id_o        = id_q;
    assign pend_mask_o = decodifica(out_v_q, dados_q.registro);

endmodule

// File: rtl/arbitro_escrita_reg.sv
// Two-requester arbiter for the bank's single write port; ARB_RR_EN selects round-robin, else fixed priority.
// Latency: grant is combinational, write reaches the bank port one cycle after transfer.
// Backpressure: both ready low while reset or while a stalled write occupies the output stage.
module arbitro_escrita_reg
    import pkg_uniciclo::*;
#(
    parameter int LARGURA_DADO = pkg_uniciclo::LARGURA_DADO,
    parameter int LARGURA_END  = pkg_uniciclo::LARGURA_END
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [LARGURA_END-1:0]  req0_reg,
    input  logic [LARGURA_DADO-1:0] req0_dado,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [LARGURA_END-1:0]  req1_reg,
    input  logic [LARGURA_DADO-1:0] req1_dado,
    input  logic                    stall,
    output logic                    EscreveReg,
    output logic [LARGURA_END-1:0]  regEscrito,
    output logic [LARGURA_DADO-1:0] dadoEscrito,
    output logic                    grant_id,
    output logic [NUM_REGS-1:0]     pend_mask,
    input  logic [LARGURA_END-1:0]  inRA,
    input  logic [LARGURA_END-1:0]  in1,
    input  logic [LARGURA_END-1:0]  in2,
    output logic                    hazard
);

    logic         out_v;
    logic         aceita;
    logic         prioriza1;
    logic         vence1;
    logic         carrega;
    logic         ultimo_q, ultimo_d;
    req_escrita_t entrada;

    assign aceita = !reset && (!out_v || !stall);

    // Contention rule: which requester wins when both are valid.
    always_comb begin
`ifdef ARB_RR_EN
        // Alternate: whoever was not granted last goes first.
        prioriza1 = (ultimo_q == 1'b0);
`else
        prioriza1 = 1'b0;
`endif
    end

`ifndef ARB_RR_EN
    // Last grant is still tracked in fixed-priority builds but does not steer the grant.
    logic ultimo_unused;
    assign ultimo_unused = ultimo_q;
`endif

    assign vence1     = req1_valid && (!req0_valid || prioriza1);
    assign req0_ready = aceita && req0_valid && !vence1;
    assign req1_ready = aceita && vence1;
    assign carrega    = req0_ready || req1_ready;

    // Mux the winning request into the output stage.
    always_comb begin
        entrada = '0;
        if (vence1) begin
            entrada.registro = req1_reg;
            entrada.dado     = req1_dado;
        end else begin
            entrada.registro = req0_reg;
            entrada.dado     = req0_dado;
        end
    end

    // Remember the last granted requester.
    always_comb begin
        ultimo_d = ultimo_q;
        if (carrega) begin
            ultimo_d = vence1;
        end
    end

    // Starts at 1 so requester 0 wins the first contention after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo_q <= 1'b1;
        end else begin
            ultimo_q <= ultimo_d;
        end
    end

    estagio_saida_escrita u_estagio (
        .clock       (clock),
        .reset       (reset),
        .carrega_i   (carrega),
        .stall_i     (stall),
        .entrada_i   (entrada),
        .id_i        (vence1),
        .out_v_o     (out_v),
        .escreve_o   (EscreveReg),
        .reg_o       (regEscrito),
        .dado_o      (dadoEscrito),
        .id_o        (grant_id),
        .pend_mask_o (pend_mask)
    );

    assign hazard = pend_mask[inRA] | pend_mask[in1] | pend_mask[in2];

endmodule

// File: tb/tb_arbitro_escrita_reg.sv
// Scoreboard bench for arbitro_escrita_reg: stimulus pushes expected writes, a monitor pops them.
// Latency: checks the one-cycle transfer-to-write path and stall/reset behaviour.
// Backpressure: exercises stall with full and empty stage.
module tb_arbitro_escrita_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0] req0_reg, req1_reg;
    logic [7:0] req0_dado, req1_dado;
    logic       stall;
    logic       EscreveReg;
    logic [1:0] regEscrito;
    logic [7:0] dadoEscrito;
    logic       grant_id;
    logic [3:0] pend_mask;
    logic [1:0] inRA, in1, in2;
    logic       hazard;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] r;
        logic [7:0] d;
        logic       id;
    } esp_t;
    esp_t fila[$];

    logic [7:0] banco [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

    arbitro_escrita_reg dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_reg    (req0_reg),
        .req0_dado   (req0_dado),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_reg    (req1_reg),
        .req1_dado   (req1_dado),
        .stall       (stall),
        .EscreveReg  (EscreveReg),
        .regEscrito  (regEscrito),
        .dadoEscrito (dadoEscrito),
        .grant_id    (grant_id),
        .pend_mask   (pend_mask),
        .inRA        (inRA),
        .in1         (in1),
        .in2         (in2),
        .hazard      (hazard)
    );

    always #5 clock = ~clock;

    // Downstream register bank model.
    always @(posedge clock) begin
        if (EscreveReg === 1'b1) banco[regEscrito] <= dadoEscrito;
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    task automatic proximo();
        @(posedge clock);
        #1;
    endtask

    task automatic meio();
        @(negedge clock);
    endtask

    task automatic empurra(input logic [1:0] r, input logic [7:0] d, input logic id);
        esp_t e;
        e.r = r; e.d = d; e.id = id;
        fila.push_back(e);
    endtask

    // Monitor: every bank write must match the oldest expected write.
    always @(negedge clock) begin
        if (EscreveReg === 1'b1) begin
            if (fila.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got reg=%0d dado=%0d expected no write", regEscrito, dadoEscrito);
            end else begin
                esp_t e;
                e = fila.pop_front();
                chk("mon_reg",  32'(regEscrito),  32'(e.r));
                chk("mon_dado", 32'(dadoEscrito), 32'(e.d));
                chk("mon_id",   32'(grant_id),    32'(e.id));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic w;
        reset = 1'b1; stall = 1'b0;
        req0_valid = 1'b0; req0_reg = 2'd1; req0_dado = 8'd3;
        req1_valid = 1'b0; req1_reg = 2'd0; req1_dado = 8'd0;
        inRA = 2'd0; in1 = 2'd0; in2 = 2'd0;
        proximo(); proximo();
        req0_valid = 1'b1;
        meio();
        chk("rst_escreve",  32'(EscreveReg),  0);
        chk("rst_reg",      32'(regEscrito),  0);
        chk("rst_dado",     32'(dadoEscrito), 0);
        chk("rst_grant",    32'(grant_id),    0);
        chk("rst_pend",     32'(pend_mask),   0);
        chk("rst_hazard",   32'(hazard),      0);
        chk("rst_ready0",   32'(req0_ready),  0);
        chk("rst_ready1",   32'(req1_ready),  0);

        // Single write reg1 <= 3, then hazard checks against the held write.
        proximo(); reset = 1'b0;
        meio();
        chk("single_ready0", 32'(req0_ready), 1);
        chk("single_ready1", 32'(req1_ready), 0);
        empurra(2'd1, 8'd3, 1'b0);
        proximo(); req0_valid = 1'b0; in1 = 2'd1;
        meio();
        chk("single_escreve", 32'(EscreveReg), 1);
        chk("single_pend",    32'(pend_mask),  32'h2);
        chk("hazard_hit",     32'(hazard),     1);
        inRA = 2'd3; in1 = 2'd0; in2 = 2'd2;
        #1;
        chk("hazard_miss",    32'(hazard),     0);
        proximo(); inRA = 2'd0; in2 = 2'd0;
        meio();
        chk("single_drained", 32'(pend_mask),  0);
        chk("single_idle",    32'(EscreveReg), 0);
        chk("bank_r1_first",  32'(banco[1]),   3);

        // Contention: both held valid for four grants.
        proximo();
        req0_valid = 1'b1; req0_reg = 2'd2; req0_dado = 8'd11;
        req1_valid = 1'b1; req1_reg = 2'd3; req1_dado = 8'd12;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            w = (k % 2 == 0);
`else
            w = 1'b0;
`endif
            meio();
            chk("cont_ready0", 32'(req0_ready), 32'(!w));
            chk("cont_ready1", 32'(req1_ready), 32'(w));
            if (k > 0) chk("cont_escreve", 32'(EscreveReg), 1);
            if (w) empurra(2'd3, 8'd12, 1'b1);
            else   empurra(2'd2, 8'd11, 1'b0);
            proximo();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        meio();
        chk("cont_last_escreve", 32'(EscreveReg), 1);

        // Stall with a full stage; reload on the cycle stall falls.
        proximo();
        req1_valid = 1'b1; req1_reg = 2'd3; req1_dado = 8'd12;
        meio();
        chk("stall_acc_ready1", 32'(req1_ready), 1);
        chk("stall_acc_ready0", 32'(req0_ready), 0);
        empurra(2'd3, 8'd12, 1'b1);
        proximo();
        req1_valid = 1'b0; stall = 1'b1;
        req0_valid = 1'b1; req0_reg = 2'd0; req0_dado = 8'd7;
        repeat (3) begin
            meio();
            chk("stall_escreve", 32'(EscreveReg), 0);
            chk("stall_pend",    32'(pend_mask),  32'h8);
            chk("stall_ready0",  32'(req0_ready), 0);
            chk("stall_ready1",  32'(req1_ready), 0);
            proximo();
        end
        stall = 1'b0;
        meio();
        chk("unstall_escreve", 32'(EscreveReg), 1);
        chk("unstall_reg",     32'(regEscrito), 3);
        chk("reload_ready0",   32'(req0_ready), 1);
        empurra(2'd0, 8'd7, 1'b0);
        proximo(); req0_valid = 1'b0;
        meio();
        chk("reload_escreve", 32'(EscreveReg), 1);
        chk("reload_reg",     32'(regEscrito), 0);

        // Stall with an empty stage: one write is accepted and held.
        proximo();
        stall = 1'b1; req0_valid = 1'b1; req0_reg = 2'd1; req0_dado = 8'd4;
        meio();
        chk("stall_empty_ready0",  32'(req0_ready), 1);
        chk("stall_empty_escreve", 32'(EscreveReg), 0);
        empurra(2'd1, 8'd4, 1'b0);
        proximo(); req0_valid = 1'b0;
        meio();
        chk("stall_held_escreve", 32'(EscreveReg), 0);
        chk("stall_held_pend",    32'(pend_mask),  32'h2);
        proximo(); stall = 1'b0;
        meio();
        chk("stall_release_escreve", 32'(EscreveReg), 1);
        chk("stall_release_reg",     32'(regEscrito), 1);

        // Same-register collision, with requester 1 granted last beforehand.
        proximo();
        req1_valid = 1'b1; req1_reg = 2'd0; req1_dado = 8'd1;
        meio();
        chk("pre_coll_ready1", 32'(req1_ready), 1);
        empurra(2'd0, 8'd1, 1'b1);
        proximo();
        req1_reg = 2'd2; req1_dado = 8'd9;
        req0_valid = 1'b1; req0_reg = 2'd2; req0_dado = 8'd5;
        meio();
        chk("coll_first_ready0", 32'(req0_ready), 1);
        chk("coll_first_ready1", 32'(req1_ready), 0);
        empurra(2'd2, 8'd5, 1'b0);
        proximo(); req0_valid = 1'b0;
        meio();
        chk("coll_second_ready1", 32'(req1_ready), 1);
        empurra(2'd2, 8'd9, 1'b1);
        proximo(); req1_valid = 1'b0;
        meio();
        proximo();
        meio();
        chk("coll_bank_r2", 32'(banco[2]), 9);

        // Reset mid-operation: the held write to reg1 must be discarded.
        proximo();
        req0_valid = 1'b1; req0_reg = 2'd1; req0_dado = 8'd8;
        meio();
        chk("rstmid_accept", 32'(req0_ready), 1);
        proximo();
        reset = 1'b1; req0_reg = 2'd0; req0_dado = 8'd1;
        meio();
        chk("rstmid_escreve", 32'(EscreveReg), 0);
        chk("rstmid_ready0",  32'(req0_ready), 0);
        proximo(); reset = 1'b0;
        meio();
        chk("rstmid_pend",       32'(pend_mask),  0);
        chk("rstmid_idle",       32'(EscreveReg), 0);
        chk("rstmid_first_gnt",  32'(req0_ready), 1);
        empurra(2'd0, 8'd1, 1'b0);
        proximo(); req0_valid = 1'b0;
        meio();
        chk("rstmid_after_escreve", 32'(EscreveReg), 1);
        proximo();
        meio();

        chk("bank_r0", 32'(banco[0]), 1);
        chk("bank_r1", 32'(banco[1]), 4);
        chk("bank_r2", 32'(banco[2]), 9);
        chk("bank_r3", 32'(banco[3]), 12);
        chk("fila_vazia", 32'(fila.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
